rv64g_reg_lock_tracker: RTL and testbench

Register-lock scoreboard that produces the `locks` vector consumed by the instruction launcher. It sits beside the register file. A lock is recorded when the launcher hands an instruction to execution, and released when that instruction's result is written back. Each register keeps a counter of outstanding writes, so several in-flight writers of the same destination are tracked exactly.

---
 rtl/rv64g_pkg.sv | 7 +
 rtl/rv64g_lock_counter.sv | 30 +++
 rtl/rv64g_reg_lock_tracker.sv | 58 +++++
 tb/tb_rv64g_reg_lock_tracker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rv64g_pkg.sv
// rv64g_pkg: shared register-file sizing and index/counter types
package rv64g_pkg;
  localparam int NUM_REGS = 64;
  localparam int NUM_OUTSTANDING = 4;
  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;
  typedef logic [$clog2(NUM_OUTSTANDING+1)-1:0] lock_cnt_t;
endpackage

// File: rtl/rv64g_lock_counter.sv
// rv64g_lock_counter: saturating up/down count of outstanding writes to one register
module rv64g_lock_counter
  import rv64g_pkg::*;
#(
  parameter int NOS = NUM_OUTSTANDING,
  localparam int CW = $clog2(NOS + 1)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          clear_i,
  output logic [CW-1:0] cnt_o,
  output logic          nonzero_o,
  output logic          full_o,
  output logic          underflow_o
);
  logic up, dn;
  assign full_o = cnt_o == CW'(NOS);
  assign nonzero_o = |cnt_o;
  assign up = inc_i & ~dec_i & ~full_o;
  assign dn = dec_i & ~inc_i & nonzero_o;
  // a same-cycle lock cancels the writeback, so only a lone unlock can underflow
  assign underflow_o = dec_i & ~inc_i & ~nonzero_o;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) cnt_o <= '0;
    else if (clear_i) cnt_o <= '0;
    else if (up) cnt_o <= cnt_o + 1'b1;
    else if (dn) cnt_o <= cnt_o - 1'b1;
endmodule

// File: rtl/rv64g_reg_lock_tracker.sv
// rv64g_reg_lock_tracker: per-register outstanding-write scoreboard driving the launcher's locks vector.
// Define RV64G_REG_LOCK_TRACKER_ERR_EN to build the sticky protocol-error flag.
module rv64g_reg_lock_tracker
  import rv64g_pkg::*;
#(
  parameter int NR  = NUM_REGS,
  parameter int NOS = NUM_OUTSTANDING,
  parameter int RW  = $clog2(NR)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          clear_i,
  input  logic          lock_valid_i,
  input  logic [RW-1:0] lock_rd_i,
  output logic          lock_ready_o,
  input  logic          unlock_valid_i,
  input  logic [RW-1:0] unlock_rd_i,
  output logic [NR-1:0] locks_o,
  output logic          busy_o,
  output logic          err_o
);
  localparam int CW = $clog2(NOS + 1);
  logic [NR-1:0] inc, dec, full, uf;
  logic [NR-1:0][CW-1:0] cnt;
  logic lock_fire, unused_sig;
  assign full[0] = 1'b0;
  assign uf[0] = 1'b0;
  assign cnt[0] = '0;
  assign locks_o[0] = 1'b0;
  assign lock_ready_o = ~full[lock_rd_i];
  assign lock_fire = lock_valid_i & lock_ready_o;
  assign inc = NR'(lock_fire) << lock_rd_i;
  assign dec = NR'(unlock_valid_i) << unlock_rd_i;
  assign busy_o = |locks_o;
  for (genvar r = 1; r < NR; r++) begin : g_cnt
    rv64g_lock_counter #(.NOS(NOS)) u_cnt (
      .clk_i      (clk_i),
      .arst_i     (arst_i),
      .inc_i      (inc[r]),
      .dec_i      (dec[r]),
      .clear_i    (clear_i),
      .cnt_o      (cnt[r]),
      .nonzero_o  (locks_o[r]),
      .full_o     (full[r]),
      .underflow_o(uf[r])
    );
  end
`ifdef RV64G_REG_LOCK_TRACKER_ERR_EN
  assign unused_sig = ^{cnt, inc[0], dec[0]};
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) err_o <= 1'b0;
    else if (clear_i) err_o <= 1'b0;
    else err_o <= err_o | (|uf) | (lock_valid_i & ~lock_ready_o);
`else
  assign unused_sig = ^{cnt, inc[0], dec[0], uf};
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_rv64g_reg_lock_tracker.sv
// tb_rv64g_reg_lock_tracker: directed plan plus randomized traffic against a count-array model
module tb_rv64g_reg_lock_tracker;
  localparam int NR = 64, NOS = 4;
`ifdef RV64G_REG_LOCK_TRACKER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 0, arst = 1, clear = 0, lv = 0, uv = 0;
  logic ready, busy, err;
  logic [5:0] lrd = 0, urd = 0;
  logic [63:0] locks;
  int m_cnt[NR];
  bit m_err = 0, chk_en = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  rv64g_reg_lock_tracker dut (
    .clk_i(clk), .arst_i(arst), .clear_i(clear),
    .lock_valid_i(lv), .lock_rd_i(lrd), .lock_ready_o(ready),
    .unlock_valid_i(uv), .unlock_rd_i(urd),
    .locks_o(locks), .busy_o(busy), .err_o(err)
  );

  function automatic logic [63:0] m_locks();
    logic [63:0] v = '0;
    for (int r = 1; r < NR; r++) v[r] = m_cnt[r] != 0;
    return v;
  endfunction

  function automatic bit m_ready();
    return lrd == 0 || m_cnt[lrd] != NOS;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("locks", locks, m_locks());
      chk("busy", 64'(busy), 64'(|m_locks()));
      chk("err", 64'(err), 64'(m_err));
      chk("ready", 64'(ready), 64'(m_ready()));
    end

  task automatic cycle();
    int nxt[NR];
    bit e, rdy, lf, u;
    nxt = m_cnt;
    e = m_err;
    rdy = m_ready();
    lf = lv && rdy;
    u = uv && urd != 0;
    if (arst || clear) begin
      foreach (nxt[r]) nxt[r] = 0;
      e = 0;
    end else begin
      if (lv && !rdy) e |= ERR_EN;
      if (!(lf && u && lrd == urd)) begin
        if (lf && lrd != 0) nxt[lrd]++;
        if (u) begin
          if (nxt[urd] > 0) nxt[urd]--;
          else e |= ERR_EN;
        end
      end
    end
    @(posedge clk);
    #1;
    m_cnt = nxt;
    m_err = e;
  endtask

  initial begin
    #1;
    chk("rst_locks", locks, 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_ready", 64'(ready), 1);
    @(posedge clk);
    #1;
    arst = 0;
    chk_en = 1;
    lv = 1; lrd = 5;
    cycle();
    lv = 0;
    #1 chk("lock5", 64'(locks[5]), 1);
    chk("busy5", 64'(busy), 1);
    cycle();
    uv = 1; urd = 5;
    cycle();
    uv = 0;
    #1 chk("unlock5", 64'(locks[5]), 0);
    chk("idle_busy", 64'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      lv = 1; lrd = 7;
      #1 chk("ready7", 64'(ready), 64'(i < 4));
      cycle();
    end
    lv = 0;
    #1 chk("sat_cnt", 64'(dut.cnt[7]), 4);
    chk("sat_model", 64'(m_cnt[7]), 4);
    chk("sat_err", 64'(err), 64'(ERR_EN));
    uv = 1; urd = 7;
    cycle();
    cycle();
    lv = 1; lrd = 7;
    cycle();
    lv = 0;
    #1 chk("same_cnt", 64'(dut.cnt[7]), 2);
    cycle();
    #1 chk("x7_one_left", 64'(locks[7]), 1);
    cycle();
    uv = 0;
    #1 chk("x7_free", 64'(locks[7]), 0);
    clear = 1;
    cycle();
    clear = 0;
    #1 chk("clr_err", 64'(err), 0);
    lv = 1; lrd = 0;
    repeat (10) begin
      #1 chk("ready_x0", 64'(ready), 1);
      cycle();
    end
    lv = 0;
    #1 chk("x0_lock", 64'(locks[0]), 0);
    chk("x0_err", 64'(err), 0);
    uv = 1; urd = 9;
    cycle();
    uv = 0;
    #1 chk("uf_locks", locks, 0);
    chk("uf_err", 64'(err), 64'(ERR_EN));
    clear = 1;
    cycle();
    clear = 0;
    #1 chk("uf_clr", 64'(err), 0);
    lv = 1; lrd = 3;
    cycle();
    lrd = 40;
    cycle();
    lv = 0;
    #1 chk("pend", locks, 64'h0000_0100_0000_0008);
    clear = 1;
    cycle();
    clear = 0;
    #1 chk("clr_locks", locks, 0);
    lv = 1; lrd = 3;
    cycle();
    lrd = 40;
    cycle();
    lv = 0;
    #2 arst = 1;
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_err = 0;
    #1 chk("arst_locks", locks, 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_ready", 64'(ready), 1);
    chk("arst_err", 64'(err), 0);
    cycle();
    arst = 0;
    repeat (3000) begin
      lv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 1));
      lrd = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      urd = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      clear = $urandom_range(0, 63) == 0;
      cycle();
    end
    lv = 0; uv = 0; clear = 0;
    cycle();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
